// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction encoder: field types, bit positions,
// immediate widths and the loader FSM state encoding.
package isa_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 4;

  typedef enum logic [1:0] {
    FT_REG    = 2'b00,
    FT_MEM    = 2'b01,
    FT_BRANCH = 2'b10,
    FT_KERNEL = 2'b11
  } funtype_t;

  localparam logic [1:0] FC_CMP = 2'b11;
  localparam logic [1:0] FC_MOV = 2'b10;

  localparam int unsigned FUNTYPE_LSB = 30;
  localparam int unsigned FUNCODE_LSB = 28;
  localparam int unsigned RD_LSB      = 24;
  localparam int unsigned RS_LSB      = 20;
  localparam int unsigned RX_LSB      = 16;
  localparam int unsigned SEL_BIT     = 0;

  localparam int unsigned IMM4_W  = 4;
  localparam int unsigned IMM19_W = 19;
  localparam int unsigned IMM28_W = 28;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_FLUSH = 2'b10,
    ST_DONE  = 2'b11
  } encoder_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset; head word is read combinationally.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  // Gate the head so stale storage never shows on the output while empty.
  assign o_rdata   = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// Program loader: encodes field beats into ISA words, queues them and streams them
// into instruction memory at consecutive addresses.
module instruction_encoder
  import isa_pkg::*;
#(
  parameter int unsigned bus       = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [bus-1:0]    base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_funtype,
  input  logic [1:0]        in_funcode,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [REG_W-1:0]  in_rs,
  input  logic [REG_W-1:0]  in_rx,
  input  logic [bus-1:0]    in_imm,
  input  logic              in_selimm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [bus-1:0]    mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [bus-1:0]    word_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  encoder_state_t    r_state;
  encoder_state_t    w_next_state;
  logic [bus-1:0]    r_addr;
  logic [bus-1:0]    r_count;
  logic              r_err;
  logic [WORD_W-1:0] w_word;
  logic              w_range_err;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_start_acc;
  logic [WORD_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_fifo_count;

  assign in_ready    = (r_state == ST_LOAD) && !w_full;
  assign w_accept    = in_valid && in_ready;
  assign w_push      = w_accept && !w_range_err;
  assign w_pop       = mem_we && mem_ready;
  assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  assign mem_we     = !w_empty;
  assign mem_wdata  = w_head;
  assign mem_addr   = r_addr;
  assign word_count = r_count;
  assign err        = r_err;
  assign busy       = (r_state == ST_LOAD) || (r_state == ST_FLUSH);
  assign done       = (r_state == ST_DONE);

  // Field packing and immediate range check for the beat on the input port.
  always_comb begin
    w_word      = '0;
    w_range_err = 1'b0;
    w_word[FUNTYPE_LSB +: 2]     = in_funtype;
    w_word[FUNCODE_LSB +: 2]     = in_funcode;
    w_word[RD_LSB +: REG_W]      = in_rd;
    case (funtype_t'(in_funtype))
      FT_REG: begin
        w_word[RS_LSB +: REG_W] = (in_funcode == FC_CMP) ? '0 : in_rs;
        if (in_selimm) begin
          w_word[SEL_BIT+1 +: IMM19_W] = in_imm[IMM19_W-1:0];
          w_word[SEL_BIT]              = 1'b1;
          w_range_err                  = ((in_imm >> IMM19_W) != '0);
        end else begin
          w_word[RX_LSB +: REG_W] = in_rx;
        end
      end
      FT_BRANCH: begin
        // Branch target overwrites rd; bit 0 doubles as the immediate flag.
        w_word[IMM28_W-1:0] = in_imm[IMM28_W-1:0];
        w_range_err         = ((in_imm >> IMM28_W) != '0) || !in_imm[0];
      end
      default: begin
        w_word[RS_LSB +: REG_W] = in_selimm ? in_imm[IMM4_W-1:0] : in_rs;
        w_word[RX_LSB +: REG_W] = in_rx;
        w_word[SEL_BIT]         = in_selimm;
        w_range_err             = in_selimm && ((in_imm >> IMM4_W) != '0);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_LOAD;
      ST_LOAD:  if (w_accept && in_last) w_next_state = ST_FLUSH;
      ST_FLUSH: if (w_fifo_count == '0) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = start ? ST_LOAD : ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Session address/count/error tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (w_start_acc) begin
      r_addr  <= base_addr;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_addr  <= r_addr + bus'(ADDR_STEP);
        r_count <= r_count + bus'(1);
      end
      if (w_accept && w_range_err) begin
        r_err <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_word),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count)
  );

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed + randomized bench for instruction_encoder with an arithmetic reference
// encoder and an expected-write scoreboard.
module tb_instruction_encoder;

  localparam longint P16 = 64'd65536;
  localparam longint P19 = 64'd524288;
  localparam longint P20 = 64'd1048576;
  localparam longint P24 = 64'd16777216;
  localparam longint P28 = 64'd268435456;
  localparam longint P30 = 64'd1073741824;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_funtype;
  logic [1:0]  in_funcode;
  logic [3:0]  in_rd;
  logic [3:0]  in_rs;
  logic [3:0]  in_rx;
  logic [31:0] in_imm;
  logic        in_selimm;
  logic        in_last;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] word_count;

  int          checks;
  int          errors;
  logic [31:0] exp_q[$];
  logic [31:0] exp_base;
  logic [31:0] exp_count;
  logic        exp_err;
  bit          rnd_rdy;

  instruction_encoder #(.bus(32), .DEPTH(4), .ADDR_STEP(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_funtype(in_funtype),
    .in_funcode(in_funcode), .in_rd(in_rd), .in_rs(in_rs), .in_rx(in_rx),
    .in_imm(in_imm), .in_selimm(in_selimm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .done(done), .err(err),
    .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoder: returns {legal, word} built by positional arithmetic.
  function automatic logic [32:0] ref_enc(input logic [1:0] ft, input logic [1:0] fc,
                                          input logic [3:0] rd, input logic [3:0] rs,
                                          input logic [3:0] rx, input logic [31:0] imm,
                                          input logic sel);
    longint v;
    longint lrd;
    longint lrs;
    longint lrx;
    longint limm;
    logic   ok;
    lrd  = longint'(rd);
    lrs  = longint'(rs);
    lrx  = longint'(rx);
    limm = longint'(imm);
    v    = longint'(ft) * P30 + longint'(fc) * P28;
    case (ft)
      2'b00: begin
        ok = !sel || (limm < P19);
        v  = v + lrd * P24 + ((fc == 2'b11) ? longint'(0) : lrs) * P20
               + (sel ? (limm * 2 + 1) : lrx * P16);
      end
      2'b10: begin
        ok = (limm < P28) && ((limm % 2) == 1);
        v  = v + (limm % P28);
      end
      default: begin
        ok = !sel || (limm < 16);
        v  = v + lrd * P24 + (sel ? limm : lrs) * P20 + lrx * P16 + (sel ? longint'(1) : longint'(0));
      end
    endcase
    return {ok, 32'(v)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: update the model from what happens at this edge, then advance.
  task automatic step();
    logic        fire;
    logic        acc;
    logic        st;
    logic        rs_now;
    logic [32:0] r;
    if (rnd_rdy) mem_ready = 1'($urandom_range(0, 1));
    rs_now = !rst;
    fire   = mem_we && mem_ready && rst;
    acc    = in_valid && in_ready && rst;
    st     = start && !busy && rst;
    if (fire) begin
      chk("wr_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        chk("wr_addr", mem_addr, exp_base + exp_count * 4);
        chk("wr_data", mem_wdata, exp_q.pop_front());
        exp_count++;
      end
    end
    if (st) begin
      exp_base  = base_addr;
      exp_count = 0;
      exp_err   = 1'b0;
    end
    if (acc) begin
      r = ref_enc(in_funtype, in_funcode, in_rd, in_rs, in_rx, in_imm, in_selimm);
      if (r[32]) exp_q.push_back(r[31:0]);
      else exp_err = 1'b1;
    end
    if (rs_now) begin
      exp_q.delete();
      exp_base  = 0;
      exp_count = 0;
      exp_err   = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input logic [31:0] base);
    start     = 1'b1;
    base_addr = base;
    step();
    start = 1'b0;
    chk("sess_busy", 32'(busy), 32'd1);
    chk("sess_count", word_count, 32'd0);
    chk("sess_err", 32'(err), 32'd0);
  endtask

  task automatic send(input logic [1:0] ft, input logic [1:0] fc, input logic [3:0] rd,
                      input logic [3:0] rs, input logic [3:0] rx, input logic [31:0] imm,
                      input logic sel, input logic last);
    logic got;
    got        = 1'b0;
    in_funtype = ft;
    in_funcode = fc;
    in_rd      = rd;
    in_rs      = rs;
    in_rx      = rx;
    in_imm     = imm;
    in_selimm  = sel;
    in_last    = last;
    in_valid   = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      got = in_ready;
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("send_accept", 32'(got), 32'd1);
  endtask

  task automatic rand_send(input logic last, input logic allow_bad);
    logic [1:0]  ft;
    logic        sel;
    logic        bad;
    logic [31:0] imm;
    ft  = 2'($urandom_range(0, 3));
    sel = 1'($urandom_range(0, 1));
    bad = allow_bad && ($urandom_range(0, 4) == 0);
    imm = $urandom;
    case (ft)
      2'b00: if (sel) imm = bad ? 32'h0008_0000 + $urandom_range(0, 1000) : $urandom_range(0, 32'h7FFFF);
      2'b10: imm = bad ? (($urandom_range(0, 1) == 1) ? (32'h1000_0001 | $urandom) : ($urandom & 32'h0FFF_FFFE))
                       : (($urandom & 32'h0FFF_FFFF) | 32'd1);
      default: if (sel) imm = bad ? 32'd16 + $urandom_range(0, 100) : $urandom_range(0, 15);
    endcase
    send(ft, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
         4'($urandom_range(0, 15)), imm, sel, last);
  endtask

  task automatic finish_session();
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      if (done) seen = 1'b1;
      else step();
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_count", word_count, exp_count);
    chk("done_err", 32'(err), 32'(exp_err));
    chk("done_drained", 32'(exp_q.size()), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    step();
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] w0;
    checks     = 0;
    errors     = 0;
    rnd_rdy    = 1'b0;
    rst        = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    in_valid   = 1'b0;
    in_funtype = '0;
    in_funcode = '0;
    in_rd      = '0;
    in_rs      = '0;
    in_rx      = '0;
    in_imm     = '0;
    in_selimm  = 1'b0;
    in_last    = 1'b0;
    mem_ready  = 1'b0;
    exp_base   = '0;
    exp_count  = '0;
    exp_err    = 1'b0;
    #1;
    step();
    step();
    rst = 1'b1;
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_count", word_count, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);

    // Single reg beat with latency check.
    mem_ready = 1'b1;
    start_session(32'h100);
    send(2'b00, 2'b00, 4'd3, 4'd1, 4'd2, 32'd0, 1'b0, 1'b1);
    chk("t1_we", 32'(mem_we), 32'd1);
    chk("t1_word", mem_wdata, 32'h0312_0000);
    chk("t1_addr", mem_addr, 32'h100);
    finish_session();
    chk("t1_count", word_count, 32'd1);

    // Reg immediate at limit, then out of range on the last beat.
    start_session(32'h200);
    send(2'b00, 2'b01, 4'd5, 4'd4, 4'd0, 32'h7FFFF, 1'b1, 1'b0);
    chk("t2_word", mem_wdata, 32'h154F_FFFF);
    send(2'b00, 2'b01, 4'd5, 4'd4, 4'd0, 32'h80000, 1'b1, 1'b1);
    chk("t2_err", 32'(err), 32'd1);
    finish_session();

    // Mem immediate legal then too wide.
    start_session(32'h300);
    send(2'b01, 2'b00, 4'd2, 4'd7, 4'd0, 32'd9, 1'b1, 1'b0);
    chk("t3_word", mem_wdata, 32'h4290_0001);
    send(2'b01, 2'b00, 4'd2, 4'd7, 4'd0, 32'd16, 1'b1, 1'b1);
    chk("t3_err", 32'(err), 32'd1);
    finish_session();

    // Branch odd/even target, then CMP clears rs.
    start_session(32'h400);
    send(2'b10, 2'b00, 4'd0, 4'd0, 4'd0, 32'h11, 1'b0, 1'b0);
    chk("t4_br", mem_wdata, 32'h8000_0011);
    send(2'b10, 2'b00, 4'd0, 4'd0, 4'd0, 32'h10, 1'b0, 1'b0);
    chk("t4_err", 32'(err), 32'd1);
    send(2'b00, 2'b11, 4'd6, 4'd9, 4'd1, 32'd0, 1'b0, 1'b1);
    chk("t4_cmp", mem_wdata, 32'h3601_0000);
    finish_session();

    // Backpressure: FIFO fills, outputs hold, late start ignored.
    mem_ready = 1'b0;
    start_session(32'h100);
    for (int i = 0; i < 4; i++) rand_send(1'b0, 1'b0);
    w0 = exp_q[0];
    in_funtype = 2'b01;
    in_funcode = 2'b10;
    in_rd      = 4'd1;
    in_rs      = 4'd2;
    in_rx      = 4'd3;
    in_imm     = 32'd5;
    in_selimm  = 1'b1;
    in_valid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_full_ready", 32'(in_ready), 32'd0);
      chk("t5_hold_we", 32'(mem_we), 32'd1);
      chk("t5_hold_addr", mem_addr, 32'h100);
      chk("t5_hold_data", mem_wdata, w0);
      start     = (i == 1);
      base_addr = 32'h999;
      step();
    end
    start     = 1'b0;
    mem_ready = 1'b1;
    send(2'b01, 2'b10, 4'd1, 4'd2, 4'd3, 32'd5, 1'b1, 1'b0);
    rand_send(1'b1, 1'b0);
    finish_session();
    chk("t5_count", word_count, 32'd6);

    // Reset during FLUSH discards queued words.
    mem_ready = 1'b0;
    start_session(32'h500);
    rand_send(1'b0, 1'b0);
    rand_send(1'b0, 1'b0);
    rand_send(1'b1, 1'b0);
    chk("t6_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t6_we", 32'(mem_we), 32'd0);
    chk("t6_busy_clr", 32'(busy), 32'd0);
    chk("t6_count", word_count, 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    mem_ready = 1'b1;
    start_session(32'h40);
    send(2'b00, 2'b00, 4'd3, 4'd1, 4'd2, 32'd0, 1'b0, 1'b1);
    finish_session();

    // Random sessions with random backpressure and illegal beats, first one wrapping.
    rnd_rdy = 1'b1;
    for (int s = 0; s < 3; s++) begin
      start_session((s == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC));
      for (int b = 0; b < 10; b++) rand_send(b == 9, 1'b1);
      finish_session();
    end
    rnd_rdy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
